vga_sync_timing: RTL
====================

// Module: vga_sync_timing
// PURPOSE
//   Generates VGA raster timing directly upstream of the pixel colour stage.
//   Divides the system clock into a pixel-rate enable and runs horizontal and
//   vertical counters. Drives pixel_x/pixel_y/video_on to the colour stage and
//   hsync/vsync to the connector. All outputs are registered and mutually aligned.
// PARAMETERS
//   H_DISPLAY  640  visible pixels per line
//   H_FRONT    16   horizontal front porch, pixels
//   H_SYNC     96   horizontal sync width, pixels
//   H_BACK     48   horizontal back porch, pixels
//   V_DISPLAY  480  visible lines per frame
//   V_FRONT    10   vertical front porch, lines
//   V_SYNC     2    vertical sync width, lines
//   V_BACK     33   vertical back porch, lines
//   TICK_DIV   2    clk cycles per pixel, >=1 (2: 50 MHz clk -> 25 MHz pixel rate)
//   SYNC_POL   0    active sync level (0 = active-low, 1 = active-high)
// PORTS
//   clk          in   1   system clock
//   rst          in   1   synchronous reset, active-high
//   pixel_tick   out  1   1-clk pulse: new pixel_x/pixel_y/syncs valid from this cycle
//   pixel_x      out  10  current column, 0..H_TOTAL-1
//   pixel_y      out  10  current row, 0..V_TOTAL-1
//   video_on     out  1   1 when pixel_x<H_DISPLAY and pixel_y<V_DISPLAY
//   hsync        out  1   horizontal sync, polarity per SYNC_POL
//   vsync        out  1   vertical sync, polarity per SYNC_POL
//   frame_start  out  1   1-clk pulse, coincident with pixel_tick, when (0,0) is presented
// BEHAVIOUR
//   - H_TOTAL = sum of the H_* params (800); V_TOTAL = sum of the V_* params (525).
//     Both must be <=1024. Counters are 10-bit unsigned.
//   - Divider: div_cnt counts 0..TICK_DIV-1 and wraps. tick_en = (div_cnt==TICK_DIV-1).
//     With TICK_DIV=1, tick_en is always 1.
//   - On a clk edge with tick_en:
//     - h advances; at H_TOTAL-1 it wraps to 0 and v advances.
//     - v wraps to 0 at V_TOTAL-1.
//     - pixel_x, pixel_y, video_on, hsync, vsync and frame_start are registered
//       from the NEXT counter values, so they change together with zero skew.
//     - pixel_tick <= 1.
//   - On edges without tick_en: all outputs hold, except pixel_tick <= 0 and frame_start <= 0.
//   - Sync decode:
//     - hsync is active for x in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] (656..751).
//     - vsync is active for y in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] (490..491).
//     - Active level is SYNC_POL; the inactive level is ~SYNC_POL.
//   - frame_start = 1 only for the tick that presents x=0, y=0.
//   - Reset values (applied the cycle after rst is sampled high, any point in frame):
//     - div_cnt=0; pixel_x=H_TOTAL-1 (799); pixel_y=V_TOTAL-1 (524).
//     - video_on=0; hsync=vsync=~SYNC_POL; pixel_tick=0; frame_start=0.
//     These reset outputs are self-consistent: the position is in both back porches.
//   - After rst deasserts, the first tick occurs TICK_DIV cycles later. It wraps to (0,0)
//     with pixel_tick=1, frame_start=1, video_on=1.
//   - Latency: output change to downstream use is 0 cycles; consumers sample on pixel_tick.
//   - Frame period = H_TOTAL*V_TOTAL*TICK_DIV clk cycles (840000 at defaults).
//     Line period = H_TOTAL*TICK_DIV clk cycles (1600).
//   - rst dominates tick_en when both are active in the same cycle.
// TESTING
//   1. Release rst -> 2 clk later pixel_tick=1, pixel_x=0, pixel_y=0, video_on=1, frame_start=1.
//   2. Line 0 -> hsync=0 for exactly pixel_x 656..751 (96 ticks, 192 clk), 1 elsewhere;
//      video_on=0 for x 640..799.
//   3. pixel_x=799, pixel_y=10, next tick -> pixel_x=0, pixel_y=11; frame_start stays 0.
//   4. Full frame -> vsync=0 exactly for pixel_y 490..491 (1600 ticks);
//      y=524 wraps to 0; frame_start pulses exactly 840000 clk apart.
//   5. rst pulsed at (300,200) -> next cycle pixel_x=799, pixel_y=524, video_on=0,
//      hsync=vsync=1, pixel_tick=0; timing then restarts as in test 1.
//   6. TICK_DIV=1, SYNC_POL=1 -> pixel_tick high every cycle after reset;
//      frame period 420000 clk; hsync/vsync pulses are high.

Source files
------------

// File: rtl/vga_sync_timing.sv
// VGA raster timing: pixel-rate enable divider, horizontal/vertical counters and
// registered, zero-skew position, blanking, sync and frame-start outputs.
module vga_sync_timing #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned TICK_DIV  = 2,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pixel_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS        = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS        = 10'(V_DISPLAY);
  localparam logic [9:0] H_SYNC_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] H_SYNC_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] V_SYNC_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_en;
  logic             h_wrap;
  logic [9:0]       h_d, v_d;
  logic             video_on_d, hsync_act_d, vsync_act_d, frame_start_d;

  // pixel_x/pixel_y are the counters themselves; all decodes look at the next
  // position so every output updates on the same edge.
  always_comb begin
    tick_en       = (div_q == DIV_LAST);
    div_d         = tick_en ? '0 : div_q + 1'b1;
    h_wrap        = (pixel_x == H_LAST);
    h_d           = h_wrap ? 10'd0 : pixel_x + 10'd1;
    v_d           = pixel_y;
    if (h_wrap) begin
      v_d = (pixel_y == V_LAST) ? 10'd0 : pixel_y + 10'd1;
    end
    video_on_d    = (h_d < H_VIS) && (v_d < V_VIS);
    hsync_act_d   = (h_d >= H_SYNC_START) && (h_d <= H_SYNC_END);
    vsync_act_d   = (v_d >= V_SYNC_START) && (v_d <= V_SYNC_END);
    frame_start_d = (h_d == 10'd0) && (v_d == 10'd0);
  end

  // Reset parks the raster at the last pixel of the frame so the first tick
  // wraps cleanly to (0,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q       <= '0;
      pixel_x     <= H_LAST;
      pixel_y     <= V_LAST;
      video_on    <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      pixel_tick  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_q <= div_d;
      if (tick_en) begin
        pixel_x     <= h_d;
        pixel_y     <= v_d;
        video_on    <= video_on_d;
        hsync       <= hsync_act_d ? SYNC_POL : ~SYNC_POL;
        vsync       <= vsync_act_d ? SYNC_POL : ~SYNC_POL;
        pixel_tick  <= 1'b1;
        frame_start <= frame_start_d;
      end else begin
        pixel_tick  <= 1'b0;
        frame_start <= 1'b0;
      end
    end
  end

endmodule
